// File: rtl/phy_pkg.sv
// Shared lane definitions: comma symbol, byte width and the receive aligner states.
package phy_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] COM_SYM = 8'hBC;

  // Encoding 2'd3 is unused and falls back to SEARCH in the aligner.
  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    ACTIVE  = 2'd2
  } rx_state_e;

  function automatic logic is_boundary(input logic [2:0] bit_cnt);
    return (bit_cnt == 3'd7);
  endfunction

endpackage

// File: rtl/phy_rx_shift8.sv
// Serial-in byte window: 8-bit shift register with a comma comparator on the
// current (including in-flight) bit.
module phy_rx_shift8
  import phy_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COM = COM_SYM
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_data,
  output logic [BYTE_W-1:0] o_byte_cur,
  output logic              o_is_com
);

  logic [BYTE_W-1:0] r_sr;
  logic [BYTE_W-1:0] w_byte_cur;

  // The incoming bit completes the window this cycle, so the comparator sees
  // the byte one edge before it lands in the register.
  assign w_byte_cur = {r_sr[BYTE_W-2:0], i_data};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sr <= '0;
    end else begin
      r_sr <= w_byte_cur;
    end
  end

  assign o_byte_cur = w_byte_cur;
  assign o_is_com   = (w_byte_cur == COM);

endmodule

// File: rtl/phy_rx_s2p_align.sv
// Lane receiver: hunts for comma alignment, locks after COM_LOCK aligned commas,
// then emits one byte per 8 bit clocks with payload/idle flag.
module phy_rx_s2p_align
  import phy_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COM      = COM_SYM,
  parameter int                COM_LOCK = 4
) (
  input  logic              clk_32f,
  input  logic              rst,
  input  logic              data_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              byte_stb,
  output logic              active
);

  localparam logic [3:0] LOCK_TGT = 4'(COM_LOCK);

  logic [BYTE_W-1:0] w_byte_cur;
  logic              w_is_com;
  logic              w_boundary;
  logic [3:0]        w_lock_inc;

  rx_state_e         r_state;
  logic [2:0]        r_bit_cnt;
  logic [3:0]        r_lock_cnt;
  logic [BYTE_W-1:0] r_data_out;
  logic              r_valid_out;
  logic              r_byte_stb;
  logic              r_active;

  phy_rx_shift8 #(
    .COM (COM)
  ) u_shift (
    .i_clk      (clk_32f),
    .i_rst      (rst),
    .i_data     (data_in),
    .o_byte_cur (w_byte_cur),
    .o_is_com   (w_is_com)
  );

  assign w_boundary = is_boundary(r_bit_cnt);
  assign w_lock_inc = r_lock_cnt + 4'd1;

  always_ff @(posedge clk_32f) begin
    if (rst) begin
      r_state     <= SEARCH;
      r_bit_cnt   <= 3'd0;
      r_lock_cnt  <= 4'd0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_byte_stb  <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_bit_cnt  <= r_bit_cnt + 3'd1;
      r_byte_stb <= 1'b0;
      case (r_state)
        SEARCH: begin
          // A match anywhere re-phases the byte counter to this bit.
          if (w_is_com) begin
            r_bit_cnt  <= 3'd0;
            r_lock_cnt <= 4'd1;
            r_state    <= LOCKING;
          end
        end
        LOCKING: begin
          if (w_boundary) begin
            if (w_is_com) begin
              if (w_lock_inc >= LOCK_TGT) begin
                r_lock_cnt <= LOCK_TGT;
                r_state    <= ACTIVE;
                r_active   <= 1'b1;
              end else begin
                r_lock_cnt <= w_lock_inc;
              end
            end else begin
              r_lock_cnt <= 4'd0;
              r_state    <= SEARCH;
            end
          end
        end
        ACTIVE: begin
          // Commas here are idle fill; a payload 8'hBC is indistinguishable.
          if (w_boundary) begin
            r_data_out  <= w_byte_cur;
            r_valid_out <= !w_is_com;
            r_byte_stb  <= 1'b1;
          end
        end
        default: begin
          r_state     <= SEARCH;
          r_lock_cnt  <= 4'd0;
          r_data_out  <= '0;
          r_valid_out <= 1'b0;
          r_active    <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign byte_stb  = r_byte_stb;
  assign active    = r_active;

endmodule

// File: tb/tb_phy_rx_s2p_align.sv
// Directed bench for phy_rx_s2p_align: lock, payload, misalignment, aborted lock,
// mid-operation reset and embedded comma.
module tb_phy_rx_s2p_align;

  logic       clk_32f = 1'b0;
  logic       rst     = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_stb;
  logic       active;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  logic mid_stb;

  phy_rx_s2p_align dut (
    .clk_32f   (clk_32f),
    .rst       (rst),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .byte_stb  (byte_stb),
    .active    (active)
  );

  always #2 clk_32f = ~clk_32f;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives the top n bits of b, MSB first; returns 1 after the edge sampling the last one.
  task automatic send_bits(input logic [7:0] b, input int n);
    mid_stb = 1'b0;
    for (int i = 7; i > 7 - n; i--) begin
      data_in = b[i];
      @(posedge clk_32f);
      #1;
      if (i != 8 - n) mid_stb = mid_stb | byte_stb;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    data_in = 1'b0;
    repeat (4) @(posedge clk_32f);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_byte(input string tag, input logic [7:0] d, input logic v);
    check({tag, "_stb"},   {31'd0, byte_stb},  32'd1);
    check({tag, "_data"},  {24'd0, data_out},  {24'd0, d});
    check({tag, "_valid"}, {31'd0, valid_out}, {31'd0, v});
    check({tag, "_mid"},   {31'd0, mid_stb},   32'd0);
    $display("byte %s data=%02h valid=%0d stb=%0d", tag, data_out, valid_out, byte_stb);
  endtask

  initial begin
    // reset state
    do_reset();
    check("rst_data",   {24'd0, data_out},  32'h00);
    check("rst_valid",  {31'd0, valid_out}, 32'd0);
    check("rst_stb",    {31'd0, byte_stb},  32'd0);
    check("rst_active", {31'd0, active},    32'd0);

    // 1: aligned comma stream
    repeat (3) send_byte(8'hBC);
    check("t1_act_after3", {31'd0, active}, 32'd0);
    send_byte(8'hBC);
    check("t1_act_after4", {31'd0, active}, 32'd1);
    check("t1_no_stb_lock", {31'd0, byte_stb}, 32'd0);
    check("t1_data_idle", {24'd0, data_out}, 32'h00);
    send_byte(8'hBC);
    check_byte("t1_com1", 8'hBC, 1'b0);
    send_byte(8'hBC);
    check_byte("t1_com2", 8'hBC, 1'b0);

    // 2: payload after lock
    do_reset();
    repeat (4) send_byte(8'hBC);
    check("t2_active", {31'd0, active}, 32'd1);
    send_byte(8'hAA); check_byte("t2_AA", 8'hAA, 1'b1);
    send_byte(8'hBB); check_byte("t2_BB", 8'hBB, 1'b1);
    send_byte(8'hCC); check_byte("t2_CC", 8'hCC, 1'b1);
    send_byte(8'hDD); check_byte("t2_DD", 8'hDD, 1'b1);
    send_byte(8'hBC); check_byte("t2_COM", 8'hBC, 1'b0);

    // 3: three garbage bits ahead of the comma stream
    do_reset();
    send_bits(8'b1010_0000, 3);
    repeat (3) send_byte(8'hBC);
    check("t3_act_after3", {31'd0, active}, 32'd0);
    send_byte(8'hBC);
    check("t3_act_after4", {31'd0, active}, 32'd1);
    send_byte(8'h11); check_byte("t3_11", 8'h11, 1'b1);

    // 4: lock attempt aborted by a non-comma
    do_reset();
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h22);
    check("t4_abort", {31'd0, active}, 32'd0);
    repeat (3) send_byte(8'hBC);
    check("t4_relock3", {31'd0, active}, 32'd0);
    send_byte(8'hBC);
    check("t4_relock4", {31'd0, active}, 32'd1);
    send_byte(8'h33); check_byte("t4_33", 8'h33, 1'b1);

    // 5: one-cycle reset mid-byte while ACTIVE
    send_bits(8'h5A, 3);
    rst = 1'b1;
    @(posedge clk_32f);
    #1;
    rst = 1'b0;
    check("t5_data",   {24'd0, data_out},  32'h00);
    check("t5_valid",  {31'd0, valid_out}, 32'd0);
    check("t5_stb",    {31'd0, byte_stb},  32'd0);
    check("t5_active", {31'd0, active},    32'd0);
    repeat (3) send_byte(8'hBC);
    check("t5_relock3", {31'd0, active}, 32'd0);
    send_byte(8'hBC);
    check("t5_relock4", {31'd0, active}, 32'd1);
    send_byte(8'h44); check_byte("t5_44", 8'h44, 1'b1);

    // 6: payload comma is reported as idle
    send_byte(8'h55); check_byte("t6_55", 8'h55, 1'b1);
    send_byte(8'hBC); check_byte("t6_BC", 8'hBC, 1'b0);
    send_byte(8'h66); check_byte("t6_66", 8'h66, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
